// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory port arbiter: FSM states, grant ids
// and the byte-enable value that marks a read.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      RESP     = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } grant_e;

   localparam logic [3:0] BE_NONE   = 4'b0000;
   localparam int         DBG_CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and backing-memory signals of the arbiter,
// plus debug taps exposing the FSM state and starvation counter.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);

   // Handshake: a requester raises *_req with its payload and holds both stable
   // until its one-cycle *_ack; the arbiter holds mem_req and its payload stable
   // until a one-cycle mem_ack, and ignores mem_ack at any other time.
   logic                     if_req;
   logic [ADDRESS_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0]    if_rdata;
   logic                     if_ack;

   logic                     ls_req;
   logic [3:0]               ls_we;
   logic [ADDRESS_WIDTH-1:0] ls_addr;
   logic [DATA_WIDTH-1:0]    ls_wdata;
   logic [DATA_WIDTH-1:0]    ls_rdata;
   logic                     ls_ack;

   logic                     mem_req;
   logic [3:0]               mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [DATA_WIDTH-1:0]    mem_rdata;
   logic                     mem_ack;

   logic                     stall;
   logic                     bus_err;

   state_e                   dbg_state;
   logic [DBG_CNT_W-1:0]     dbg_starve_cnt;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ack, ls_rdata, ls_ack,
      output mem_req, mem_we, mem_addr, mem_wdata, stall, bus_err,
      output dbg_state, dbg_starve_cnt
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ack, ls_rdata, ls_ack,
      input  mem_req, mem_we, mem_addr, mem_wdata, stall, bus_err,
      input  dbg_state, dbg_starve_cnt
   );

endinterface

// File: rtl/mem_arb_timeout.sv
// Watchdog for an outstanding memory access: counts while run is high and
// flags expiry on the last permitted cycle; clear returns it to zero.
module mem_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Counter starts at 0 on the first waiting cycle, so expiry lands on wait cycle TIMEOUT_CYCLES.
   assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with LS priority, a bounded IF starvation window and a silent-memory watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   state_e                   state;
   grant_e                   grant;
   logic [STARVE_W-1:0]      starve_cnt;

   logic                     mem_req_q;
   logic [3:0]               mem_we_q;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0]    mem_wdata_q;
   logic [DATA_WIDTH-1:0]    if_rdata_q;
   logic [DATA_WIDTH-1:0]    ls_rdata_q;
   logic                     if_ack_q;
   logic                     ls_ack_q;
   logic                     bus_err_q;

   logic                     force_if;
   logic                     is_read;
   logic                     tmo_run;
   logic                     tmo_clear;
   logic                     tmo_expired;

   assign force_if  = bus.if_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
   assign is_read   = (grant == GNT_IF) || (mem_we_q == BE_NONE);
   assign tmo_run   = (state == WAIT_MEM);
   assign tmo_clear = (state == RESP);

   mem_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .run     (tmo_run),
      .clear   (tmo_clear),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= GNT_IF;
         starve_cnt  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= BE_NONE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         if_ack_q  <= 1'b0;
         ls_ack_q  <= 1'b0;
         bus_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ls_req && !force_if) begin
                  grant       <= GNT_LS;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.ls_we;
                  mem_addr_q  <= bus.ls_addr;
                  mem_wdata_q <= bus.ls_wdata;
                  state       <= WAIT_MEM;
                  // Only LS wins that overtake a waiting fetch count toward the limit.
                  if (!bus.if_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end else if (bus.if_req) begin
                  grant       <= GNT_IF;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= BE_NONE;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
                  starve_cnt  <= '0;
                  state       <= WAIT_MEM;
               end else begin
                  starve_cnt <= '0;
               end
            end
            WAIT_MEM: begin
               // A real ack beats a simultaneous watchdog expiry.
               if (bus.mem_ack || tmo_expired) begin
                  mem_req_q <= 1'b0;
                  bus_err_q <= !bus.mem_ack;
                  state     <= RESP;
                  if (grant == GNT_IF) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                  end else begin
                     ls_ack_q <= 1'b1;
                     if (is_read) begin
                        ls_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                     end
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req        = mem_req_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.if_rdata       = if_rdata_q;
   assign bus.if_ack         = if_ack_q;
   assign bus.ls_rdata       = ls_rdata_q;
   assign bus.ls_ack         = ls_ack_q;
   assign bus.bus_err        = bus_err_q;
   assign bus.stall          = (bus.if_req & ~if_ack_q) | (bus.ls_req & ~ls_ack_q);
   assign bus.dbg_state      = state;
   assign bus.dbg_starve_cnt = DBG_CNT_W'(starve_cnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory responder
// checks grant order against an expected queue; sequences check timing and data.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk;
   logic rst;

   mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .ADDRESS_WIDTH  (AW),
      .DATA_WIDTH     (DW),
      .STARVE_LIMIT   (4),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] exp_q[$];
   int            mem_lat    = 3;
   bit            mem_silent = 0;
   int            req_cnt    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_ack(input bit is_ls, input int max_cyc, output int cyc);
      cyc = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         step();
         if (is_ls ? bus.ls_ack : bus.if_ack) begin
            cyc = i;
            break;
         end
      end
   endtask

   function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
      return (a == 32'h4) ? 32'h0050_0093 : ~a;
   endfunction

   // Memory model: acks on the mem_lat-th cycle of mem_req unless silent.
   initial begin
      logic [AW-1:0] exp_addr;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
               exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               check("grant_addr", bus.mem_addr, exp_addr);
            end
            if (!mem_silent && req_cnt == mem_lat) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = rdata_of(bus.mem_addr);
            end else begin
               bus.mem_ack = 1'b0;
            end
         end else begin
            req_cnt     = 0;
            bus.mem_ack = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int ls_cyc, if_cyc, n_ls, max_st, hi, cyc;
      bit got_if, err_at_ack;

      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.ls_req = 1'b0; bus.ls_we = BE_NONE; bus.ls_addr = '0; bus.ls_wdata = '0;

      step();
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_if_ack", bus.if_ack, 0);
      check("rst_ls_ack", bus.ls_ack, 0);
      check("rst_bus_err", bus.bus_err, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_ls_rdata", bus.ls_rdata, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_state", bus.dbg_state, IDLE);
      step();
      rst = 1'b0;

      // IF read, ack on third mem_req cycle
      mem_lat = 3;
      exp_q.push_back(32'h4);
      bus.if_addr = 32'h4; bus.if_req = 1'b1;
      #1 check("t1_stall_req", bus.stall, 1);
      step();
      check("t1_mem_req", bus.mem_req, 1);
      check("t1_mem_we", bus.mem_we, 0);
      check("t1_mem_wdata", bus.mem_wdata, 0);
      check("t1_state", bus.dbg_state, WAIT_MEM);
      step(); step();
      check("t1_no_ack_yet", bus.if_ack, 0);
      check("t1_stall_wait", bus.stall, 1);
      step();
      check("t1_if_ack", bus.if_ack, 1);
      check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
      check("t1_mem_req_drop", bus.mem_req, 0);
      check("t1_stall_ack", bus.stall, 0);
      bus.if_req = 1'b0;
      step();
      check("t1_ack_pulse", bus.if_ack, 0);

      // Simultaneous requests: LS first, then IF
      mem_lat = 2;
      exp_q.push_back(32'h10); exp_q.push_back(32'h20);
      bus.ls_addr = 32'h10; bus.ls_we = BE_NONE; bus.ls_req = 1'b1;
      bus.if_addr = 32'h20; bus.if_req = 1'b1;
      ls_cyc = 0; if_cyc = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (bus.ls_ack) begin
            ls_cyc = c;
            check("t2_mem_req_at_ls_ack", bus.mem_req, 0);
            check("t2_starve_after_ls", bus.dbg_starve_cnt, 1);
            bus.ls_req = 1'b0;
         end
         if (bus.if_ack) begin
            if_cyc = c;
            bus.if_req = 1'b0;
            break;
         end
      end
      check("t2_ls_ack_cyc", ls_cyc, 3);
      check("t2_if_ack_cyc", if_cyc, 7);
      check("t2_ls_rdata", bus.ls_rdata, 32'hFFFF_FFEF);
      check("t2_if_rdata", bus.if_rdata, 32'hFFFF_FFDF);
      check("t2_starve_clr", bus.dbg_starve_cnt, 0);
      step();

      // Starvation: LS re-requests continuously while IF waits
      mem_lat = 1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h100);
      exp_q.push_back(32'h200);
      bus.ls_addr = 32'h100; bus.ls_req = 1'b1;
      bus.if_addr = 32'h200; bus.if_req = 1'b1;
      n_ls = 0; max_st = 0; got_if = 0;
      for (int c = 1; c <= 60; c++) begin
         step();
         if (int'(bus.dbg_starve_cnt) > max_st) max_st = int'(bus.dbg_starve_cnt);
         if (bus.ls_ack) n_ls++;
         if (bus.if_ack) begin
            got_if = 1;
            bus.ls_req = 1'b0;
            bus.if_req = 1'b0;
            break;
         end
      end
      check("t3_ls_grants", n_ls, 4);
      check("t3_if_granted", got_if, 1);
      check("t3_starve_max", max_st, 4);
      check("t3_starve_clr", bus.dbg_starve_cnt, 0);
      check("t3_if_rdata", bus.if_rdata, 32'hFFFF_FDFF);
      step();

      // Store leaves ls_rdata untouched
      mem_lat = 2;
      exp_q.push_back(32'h40);
      bus.ls_addr = 32'h40; bus.ls_we = 4'b0011; bus.ls_wdata = 32'hAABB_CCDD; bus.ls_req = 1'b1;
      step();
      check("t4_mem_we", bus.mem_we, 4'b0011);
      check("t4_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
      wait_ack(1'b1, 20, cyc);
      check("t4_ack_cyc", cyc, 2);
      check("t4_ls_rdata_kept", bus.ls_rdata, 32'hFFFF_FEFF);
      check("t4_bus_err", bus.bus_err, 0);
      bus.ls_req = 1'b0; bus.ls_we = BE_NONE;
      step();

      // Timeout on a silent memory
      mem_silent = 1;
      exp_q.push_back(32'h80);
      bus.ls_addr = 32'h80; bus.ls_req = 1'b1;
      hi = 0; cyc = 0; err_at_ack = 0;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (bus.mem_req) hi++;
         if (bus.ls_ack) begin
            cyc = c;
            err_at_ack = bus.bus_err;
            bus.ls_req = 1'b0;
            break;
         end
      end
      check("t5_mem_req_cycles", hi, 255);
      check("t5_ack_cyc", cyc, 256);
      check("t5_bus_err_with_ack", err_at_ack, 1);
      check("t5_ls_rdata_zero", bus.ls_rdata, 0);
      step();
      check("t5_bus_err_pulse", bus.bus_err, 0);
      mem_silent = 0;

      // Ack on the expiry cycle wins over the watchdog
      mem_lat = 255;
      exp_q.push_back(32'h300);
      bus.if_addr = 32'h300; bus.if_req = 1'b1;
      cyc = 0; err_at_ack = 1;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (bus.if_ack) begin
            cyc = c;
            err_at_ack = bus.bus_err;
            bus.if_req = 1'b0;
            break;
         end
      end
      check("t6_ack_cyc", cyc, 256);
      check("t6_no_bus_err", err_at_ack, 0);
      check("t6_if_rdata", bus.if_rdata, 32'hFFFF_FCFF);
      step();

      // Reset in the middle of an access, then a fresh fetch
      mem_silent = 1;
      exp_q.push_back(32'h8);
      bus.if_addr = 32'h8; bus.if_req = 1'b1;
      step(); step();
      check("t7_mem_req_before", bus.mem_req, 1);
      #3 rst = 1'b1;
      #1;
      check("t7_mem_req_async", bus.mem_req, 0);
      check("t7_if_ack_async", bus.if_ack, 0);
      check("t7_bus_err_async", bus.bus_err, 0);
      check("t7_state_async", bus.dbg_state, IDLE);
      check("t7_if_rdata_async", bus.if_rdata, 0);
      bus.if_req = 1'b0;
      step(); step();
      rst = 1'b0;
      mem_silent = 0;
      mem_lat = 2;
      exp_q.push_back(32'hC);
      bus.if_addr = 32'hC; bus.if_req = 1'b1;
      wait_ack(1'b0, 20, cyc);
      check("t7_ack_cyc", cyc, 3);
      check("t7_if_rdata", bus.if_rdata, 32'hFFFF_FFF3);
      bus.if_req = 1'b0;
      step();

      check("grants_all_seen", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the core and memory, which responds through a req/ack handshake with variable latency.
- Priority: LS over IF, with a starvation bound for IF and a watchdog timeout for a silent memory.
- Drives `stall` so the core freezes while any of its requests is outstanding.

Parameters:
- ADDRESS_WIDTH, 32: width of all address ports.
- DATA_WIDTH, 32: width of all data ports.
- STARVE_LIMIT, 4: consecutive LS grants allowed while IF is pending before IF is forced.
- TIMEOUT_CYCLES, 255: cycles of mem_req without mem_ack before the access is aborted.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDRESS_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched word; valid while if_ack.
- if_ack  out  1  one-cycle completion pulse.
- ls_req  in  1  load/store request; held with its signals stable until ls_ack.
- ls_we  in  4  byte write enables; 4'b0000 = read.
- ls_addr  in  ADDRESS_WIDTH  data address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_rdata  out  DATA_WIDTH  load data; valid while ls_ack.
- ls_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  registered request to memory.
- mem_we  out  4  registered byte enables.
- mem_addr  out  ADDRESS_WIDTH  registered address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_rdata  in  DATA_WIDTH  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  one-cycle completion from memory.
- stall  out  1  combinational: (if_req & ~if_ack) | (ls_req & ~ls_ack).
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous): all registered outputs 0, FSM in IDLE, starvation and timeout counters 0. mem_req falls immediately, even mid-access; the aborted access is not acked.
- FSM states: IDLE, WAIT_MEM, RESP.
- IDLE:
  - Grant is decided on requests sampled this cycle.
  - Priority is LS if ls_req, else IF if if_req.
  - Exception: if if_req=1 and starve_cnt==STARVE_LIMIT, IF is granted.
  - On a grant: latch the grant id; register mem_req=1 plus mem_addr/mem_we/mem_wdata; go to WAIT_MEM.
  - mem_we=0 and mem_wdata=0 for IF grants.
- WAIT_MEM:
  - mem_req and its payload are held stable; the timeout counter increments each cycle.
  - On mem_ack=1: capture mem_rdata into the granted client's rdata register (loads and fetches only; writes leave ls_rdata unchanged); drop mem_req next edge; go to RESP.
  - On timeout counter reaching TIMEOUT_CYCLES-1 without mem_ack: drop mem_req; set client rdata=0 (reads only); pulse bus_err with the RESP cycle; go to RESP.
  - If mem_ack and timeout expire in the same cycle, ack wins: no bus_err, real data captured.
- RESP:
  - Granted client's ack=1 for exactly this cycle; then go to IDLE.
  - Timeout counter clears.
  - Client may drop req or present a new one on the next cycle.
- Latency: request in IDLE at cycle 0 -> mem_req at cycle 1. mem_ack at cycle k -> client ack at k+1. Next grant can issue mem_req at k+3.
- Starvation counter:
  - Increments on each LS grant made while if_req=1.
  - Clears on any IF grant, or on an IDLE cycle with if_req=0.
  - Saturates at STARVE_LIMIT.
- A client's rdata holds its last captured value until the next capture.
- No address alignment checks; addresses pass through unmodified.
- mem_ack while not in WAIT_MEM is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, WAIT_MEM, RESP}
  - grant enum {GNT_IF, GNT_LS}
  - BE_NONE = 4'b0000
- One sub-module, mem_arb_timeout: the watchdog counter, with inputs clk, rst, run, clear and output expired. It is instantiated once.

Test Plan:
- IF read only: if_addr=0x04, memory acks on the 3rd mem_req cycle with 0x00500093 -> mem_req rises 1 cycle after if_req; if_ack pulses 1 cycle after mem_ack with if_rdata=0x00500093; stall high until that ack.
- IF and LS requests in the same cycle: LS read 0x10 is serviced first (mem_addr=0x10), then IF -> ls_ack precedes if_ack; no overlap of mem_req.
- Starvation: ls_req held high and re-requested after every ack, if_req held high -> exactly 4 LS grants, then IF is granted; starve_cnt returns to 0.
- Timeout: LS read to an address memory never acks -> mem_req falls after 255 cycles; bus_err and ls_ack pulse together; ls_rdata=0.
- Store: ls_we=4'b0011, ls_wdata=0xAABBCCDD -> mem_we=4'b0011, mem_wdata=0xAABBCCDD; after ack, ls_rdata retains its previous value.
- Reset mid-access: assert rst in WAIT_MEM -> mem_req, acks and bus_err drop without a clock edge. After release, a fresh IF request completes normally.
